// File: rtl/trace_match_sequencer_pkg.sv
// Shared state encoding and constants for the trace match sequencer.
// Pure declarations: no latency, no flow control.
package trace_match_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_RUN       = 3'd2,
    ST_FIRE      = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_t;

  localparam int          TRIG_COUNT_W   = 16;
  localparam logic [15:0] TRIG_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/trace_seq_timer.sv
// Inter-stage timeout counter: limit latched on load, tc when the next enabled cycle reaches the limit.
// Latency: tc is combinational from the count register; no flow control.
module trace_seq_timer #(
  parameter int pWIDTH = 32
) (
  input  logic              trace_clk,
  input  logic              reset_i,
  input  logic              load,
  input  logic [pWIDTH-1:0] limit,
  input  logic              clear,
  input  logic              enable,
  output logic              tc
);

  logic [pWIDTH-1:0] limit_q;
  logic [pWIDTH-1:0] cnt_q;
  logic [pWIDTH:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{pWIDTH{1'b0}}, 1'b1};
  // A limit of zero disables the timeout entirely.
  assign tc      = (limit_q != '0) && (cnt_inc >= {1'b0, limit_q});

  always_ff @(posedge trace_clk or posedge reset_i) begin
    if (reset_i) begin
      limit_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (load) limit_q <= limit;
      if (load || clear) cnt_q <= '0;
      else if (enable && !tc && (limit_q != '0)) cnt_q <= cnt_inc[pWIDTH-1:0];
    end
  end

endmodule

// File: rtl/trace_match_sequencer.sv
// Multi-stage trigger sequencer: O_trigger high the cycle after the completing hit; pulses are never stalled.
// Macro TRACE_SEQ_AUTO_REARM_EN: FIRE re-enters WAIT_SYNC and O_trigger_count counts triggers.
module trace_match_sequencer
  import trace_match_sequencer_pkg::*;
#(
  parameter int pMATCH_RULES   = 8,
  parameter int pSTAGES        = 4,
  parameter int pCOUNT_WIDTH   = 16,
  parameter int pTIMEOUT_WIDTH = 32
) (
  input  logic                              trace_clk,
  input  logic                              reset_i,
  input  logic                              I_arm,
  input  logic                              I_abort,
  input  logic                              I_synchronized,
  input  logic [pMATCH_RULES-1:0]           I_matching_pattern,
  input  logic [pSTAGES*pMATCH_RULES-1:0]   I_stage_rules,
  input  logic [pSTAGES*pCOUNT_WIDTH-1:0]   I_stage_count,
  input  logic [$clog2(pSTAGES)-1:0]        I_last_stage,
  input  logic [pTIMEOUT_WIDTH-1:0]         I_timeout,
  output logic                              O_trigger,
  output logic                              O_armed,
  output logic [2:0]                        O_state,
  output logic [$clog2(pSTAGES)-1:0]        O_stage,
  output logic [pCOUNT_WIDTH-1:0]           O_match_count,
  output logic                              O_timed_out,
  output logic [TRIG_COUNT_W-1:0]           O_trigger_count
);

  localparam int STAGE_W = $clog2(pSTAGES);

  seq_state_t                        state_q, state_d;
  logic [pSTAGES*pMATCH_RULES-1:0]   rules_q;
  logic [pSTAGES*pCOUNT_WIDTH-1:0]   counts_q;
  logic [STAGE_W-1:0]                last_q;
  logic [STAGE_W-1:0]                stage_q, stage_d;
  logic [pCOUNT_WIDTH-1:0]           count_q, count_d;
  logic                              timed_out_q, timed_out_d;
  logic                              arm_go, tmr_clr, tmr_en, tmr_tc;
  logic [pMATCH_RULES-1:0]           cur_rules;
  logic [pCOUNT_WIDTH-1:0]           cur_cnt, cnt_max;
  logic [pCOUNT_WIDTH:0]             count_inc;
  logic                              hit, stage_done;

  assign cur_rules  = rules_q[stage_q*pMATCH_RULES +: pMATCH_RULES];
  assign cur_cnt    = counts_q[stage_q*pCOUNT_WIDTH +: pCOUNT_WIDTH];
  assign cnt_max    = (cur_cnt == '0) ? {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1} : cur_cnt;
  assign count_inc  = {1'b0, count_q} + {{pCOUNT_WIDTH{1'b0}}, 1'b1};
  // Any number of simultaneous rule matches collapses to a single hit.
  assign hit        = |(I_matching_pattern & cur_rules);
  assign stage_done = count_inc >= {1'b0, cnt_max};

  trace_seq_timer #(.pWIDTH(pTIMEOUT_WIDTH)) u_timer (
    .trace_clk (trace_clk),
    .reset_i   (reset_i),
    .load      (arm_go),
    .limit     (I_timeout),
    .clear     (tmr_clr),
    .enable    (tmr_en),
    .tc        (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    count_d     = count_q;
    timed_out_d = timed_out_q;
    arm_go      = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    if (I_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (I_arm) begin
            state_d     = ST_WAIT_SYNC;
            arm_go      = 1'b1;
            stage_d     = '0;
            count_d     = '0;
            timed_out_d = 1'b0;
          end
        end
        ST_WAIT_SYNC: begin
          if (I_synchronized) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!I_synchronized) begin
            state_d = ST_WAIT_SYNC;
            stage_d = '0;
            count_d = '0;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = (stage_q != '0);
            if (hit) begin
              if (!stage_done) begin
                count_d = count_inc[pCOUNT_WIDTH-1:0];
              end else if (stage_q != last_q) begin
                stage_d = stage_q + 1'b1;
                count_d = '0;
                tmr_clr = 1'b1;
              end else begin
                state_d = ST_FIRE;
              end
            end else if ((stage_q != '0) && tmr_tc) begin
              stage_d     = '0;
              count_d     = '0;
              tmr_clr     = 1'b1;
              timed_out_d = 1'b1;
            end
          end
        end
        ST_FIRE: begin
`ifdef TRACE_SEQ_AUTO_REARM_EN
          state_d = ST_WAIT_SYNC;
          stage_d = '0;
          count_d = '0;
          tmr_clr = 1'b1;
`else
          state_d = ST_DONE;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge trace_clk or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge trace_clk or posedge reset_i) begin
    if (reset_i) begin
      rules_q     <= '0;
      counts_q    <= '0;
      last_q      <= '0;
      stage_q     <= '0;
      count_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (arm_go) begin
        rules_q  <= I_stage_rules;
        counts_q <= I_stage_count;
        last_q   <= I_last_stage;
      end
      stage_q     <= stage_d;
      count_q     <= count_d;
      timed_out_q <= timed_out_d;
    end
  end

`ifdef TRACE_SEQ_AUTO_REARM_EN
  logic [TRIG_COUNT_W-1:0] trig_cnt_q;

  always_ff @(posedge trace_clk or posedge reset_i) begin
    if (reset_i)                                    trig_cnt_q <= '0;
    else if (arm_go)                                trig_cnt_q <= '0;
    else if (!I_abort && (state_q == ST_FIRE) && (trig_cnt_q != TRIG_COUNT_MAX))
                                                    trig_cnt_q <= trig_cnt_q + 1'b1;
  end

  assign O_trigger_count = trig_cnt_q;
`else
  assign O_trigger_count = '0;
`endif

  assign O_trigger     = (state_q == ST_FIRE);
  assign O_armed       = (state_q == ST_WAIT_SYNC) || (state_q == ST_RUN);
  assign O_state       = state_q;
  assign O_stage       = stage_q;
  assign O_match_count = count_q;
  assign O_timed_out   = timed_out_q;

endmodule
